// File: rtl/bcd_tally_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_tally_display_pkg
// Description : Shared 7-segment codes (active-low {g,f,e,d,c,b,a}) and
//               digit-select type for the BCD tally display.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_tally_display_pkg;

    // Decimal digit glyphs, active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    // Status glyphs: "E", "r", "-" and all segments off
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Largest legal BCD digit
    localparam logic [3:0] BCD_MAX   = 4'd9;

    // Which digit of the display is currently lit
    typedef enum logic {
        DIG_UNITS = 1'b0,
        DIG_TENS  = 1'b1
    } digit_sel_e;

endpackage : bcd_tally_display_pkg
`default_nettype wire

// File: rtl/bcd_tally_display_seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational BCD to active-low 7-segment decoder. Values
//               above 9 decode to a blank digit.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import bcd_tally_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Digit lookup; anything outside 0-9 is blanked
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/bcd_tally_display.sv
`default_nettype none
// ============================================================================
// Module      : bcd_tally_display
// Description : Counts completed 0->9 runs of the upstream units counter as a
//               saturating BCD tens digit, raises a sticky timeout at LIMIT
//               and scans a two-digit active-low 7-segment display.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_tally_display
    import bcd_tally_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,  // cycles each digit is lit (>= 2)
    parameter logic [7:0]  LIMIT    = 8'h30   // packed BCD {tens, units}
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [3:0] bcd_i,
    input  logic       run_i,
    input  logic       error_i,
    output logic [3:0] tens_o,
    output logic       timeout_o,
    output logic       bad_digit_o,
    output logic [6:0] seg_o,
    output logic [1:0] an_o
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    // Tally state
    logic [3:0]       prev_units_q;
    logic [3:0]       tens_q, tens_d;
    logic             timeout_q, timeout_d;
    logic             bad_digit_q;

    // Scan state
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    digit_sel_e       sel_q, sel_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;

    // Combinational helpers
    logic             clear_w;
    logic             wrap_w;
    logic             at_limit_w;
    logic             bcd_bad_w;
    logic [6:0]       units_dec_w, tens_dec_w;
    logic [6:0]       units_seg_w, tens_seg_w;

    assign clear_w    = ~run_i | error_i;
    assign wrap_w     = (prev_units_q == BCD_MAX) && (bcd_i == 4'd0) && ~clear_w;
    assign at_limit_w = ({tens_q, bcd_i} >= LIMIT);
    assign bcd_bad_w  = (bcd_i > BCD_MAX);

    // One decoder per digit position
    seg7_decode u_dec_units (
        .bcd_i (bcd_i),
        .seg_o (units_dec_w)
    );

    seg7_decode u_dec_tens (
        .bcd_i (tens_q),
        .seg_o (tens_dec_w)
    );

    // Tens counter and sticky timeout; the clear takes priority over a wrap
    always_comb begin
        tens_d    = tens_q;
        timeout_d = timeout_q;
        if (clear_w) begin
            tens_d    = 4'd0;
            timeout_d = 1'b0;
        end else begin
            if (wrap_w && (tens_q != BCD_MAX)) begin
                tens_d = tens_q + 4'd1;
            end
            if (at_limit_w) begin
                timeout_d = 1'b1;
            end
        end
    end

    // Scan divider: count 0..SCAN_DIV-1, flip the lit digit at the terminal count
    always_comb begin
        scan_cnt_d = scan_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        sel_d      = sel_q;
        if (scan_cnt_q == CNT_LAST) begin
            scan_cnt_d = '0;
            sel_d      = (sel_q == DIG_UNITS) ? DIG_TENS : DIG_UNITS;
        end
    end

    // Glyph selection for the currently lit digit; error overrides everything
    always_comb begin
        units_seg_w = error_i ? SEG_R : (bcd_bad_w ? SEG_DASH : units_dec_w);
        tens_seg_w  = error_i ? SEG_E : tens_dec_w;
        if (sel_q == DIG_UNITS) begin
            seg_d = units_seg_w;
            an_d  = 2'b10;
        end else begin
            seg_d = tens_seg_w;
            an_d  = 2'b01;
        end
    end

    // State registers; seg and an are captured together so they never skew
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            prev_units_q <= 4'd0;
            tens_q       <= 4'd0;
            timeout_q    <= 1'b0;
            bad_digit_q  <= 1'b0;
            scan_cnt_q   <= '0;
            sel_q        <= DIG_UNITS;
            seg_q        <= SEG_BLANK;
            an_q         <= 2'b11;
        end else begin
            prev_units_q <= bcd_i;
            tens_q       <= tens_d;
            timeout_q    <= timeout_d;
            bad_digit_q  <= bcd_bad_w;
            scan_cnt_q   <= scan_cnt_d;
            sel_q        <= sel_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign tens_o      = tens_q;
    assign timeout_o   = timeout_q;
    assign bad_digit_o = bad_digit_q;
    assign seg_o       = seg_q;
    assign an_o        = an_q;

endmodule : bcd_tally_display
`default_nettype wire

// File: tb/tb_bcd_tally_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_tally_display
// Description : Scoreboard bench for bcd_tally_display with a behavioural
//               model of the tally, timeout and scanned display.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_tally_display;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned LIMIT    = 'h12;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] bcd;
    logic       run;
    logic       err;
    logic [3:0] tens;
    logic       timeout;
    logic       bad_digit;
    logic [6:0] seg;
    logic [1:0] an;

    bcd_tally_display #(
        .SCAN_DIV (SCAN_DIV),
        .LIMIT    (8'(LIMIT))
    ) dut (
        .clock_i     (clk),
        .reset_i     (rst),
        .bcd_i       (bcd),
        .run_i       (run),
        .error_i     (err),
        .tens_o      (tens),
        .timeout_o   (timeout),
        .bad_digit_o (bad_digit),
        .seg_o       (seg),
        .an_o        (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] tens;
        logic       to;
        logic       bad;
        logic [6:0] seg;
        logic [1:0] an;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 0;

    // Reference model state, in plain integers
    int   m_tens, m_prev, m_cyc;
    bit   m_to;
    int   digit_code[10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    task automatic model_reset();
        m_tens = 0;
        m_prev = 0;
        m_cyc  = 0;
        m_to   = 0;
    endtask

    // Apply one cycle of inputs, predict the post-edge outputs, push them
    task automatic step(input int b, input bit r, input bit e);
        exp_t x;
        bit   wrap;
        bcd = 4'(b);
        run = r;
        err = e;
        wrap = (m_prev == 9) && (b == 0) && r && !e;
        if (((m_cyc / SCAN_DIV) % 2) == 0) begin
            x.an  = 2'b10;
            x.seg = e ? 7'h2F : (b > 9 ? 7'h3F : 7'(digit_code[b]));
        end else begin
            x.an  = 2'b01;
            x.seg = e ? 7'h06 : 7'(digit_code[m_tens]);
        end
        if (!r || e) begin
            m_to   = 0;
            m_tens = 0;
        end else begin
            if (m_tens * 16 + b >= LIMIT) m_to = 1;
            if (wrap && m_tens < 9) m_tens = m_tens + 1;
        end
        m_prev = b;
        m_cyc++;
        x.tens = 4'(m_tens);
        x.to   = m_to;
        x.bad  = (b > 9);
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    task automatic count_run(input int upto);
        for (int d = 0; d <= upto; d++) step(d, 1, 0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_tens"}, 32'(tens), 32'h0);
        chk({tag, "_timeout"}, 32'(timeout), 32'h0);
        chk({tag, "_bad"}, 32'(bad_digit), 32'h0);
        chk({tag, "_seg"}, 32'(seg), 32'h7F);
        chk({tag, "_an"}, 32'(an), 32'h3);
    endtask

    // Assert reset asynchronously between edges, hold it with toggling inputs
    task automatic do_reset(input string tag);
        mon_en = 0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_state({tag, "_async"});
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            bcd = 4'($urandom_range(0, 15));
            run = 1'($urandom);
            err = 1'($urandom);
            @(negedge clk);
            chk_reset_state(tag);
        end
        rst = 1'b0;
        model_reset();
        mon_en = 1;
    endtask

    // Monitor: every edge the DUT presents a fresh output word
    always @(posedge clk) begin
        #1;
        if (mon_en && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("tens", 32'(tens), 32'(e.tens));
            chk("timeout", 32'(timeout), 32'(e.to));
            chk("bad_digit", 32'(bad_digit), 32'(e.bad));
            chk("seg", 32'(seg), 32'(e.seg));
            chk("an", 32'(an), 32'(e.an));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int u;
        rst = 1'b1;
        bcd = 4'd0;
        run = 1'b0;
        err = 1'b0;
        model_reset();

        // Reset held from time zero with inputs toggling
        for (int i = 0; i < 3; i++) begin
            bcd = 4'($urandom_range(0, 15));
            run = 1'($urandom);
            err = 1'($urandom);
            @(negedge clk);
            chk_reset_state("por");
        end
        rst = 1'b0;
        mon_en = 1;

        // Twelve full runs: tens climbs then saturates at 9, timeout sticks
        for (int r = 0; r < 12; r++) count_run(9);
        step(0, 1, 0);
        step(1, 1, 0);

        // Drop run: tens and timeout clear
        step(1, 0, 0);
        step(2, 0, 0);

        // Approach LIMIT = 12 from zero
        count_run(9);
        step(0, 1, 0);
        step(1, 1, 0);
        step(2, 1, 0);
        step(3, 1, 0);
        step(3, 0, 0);

        // Error on the same edge as a wrap, then a longer error window
        count_run(9);
        step(0, 1, 1);
        step(1, 1, 0);
        count_run(9);
        for (int i = 0; i < 2 * SCAN_DIV; i++) step(0, 1, 1);
        step(0, 1, 0);

        // Bad digit with a nonzero tens digit
        count_run(9);
        step(0, 1, 0);
        for (int i = 0; i < 2 * SCAN_DIV; i++) step(4'hC, 1, 0);
        step(1, 1, 0);

        // Randomised counter behaviour
        u = 0;
        for (int i = 0; i < 600; i++) begin
            int pick;
            pick = int'($urandom_range(0, 99));
            if (pick < 85)      u = (u == 9) ? 0 : u + 1;
            else if (pick < 92) u = int'($urandom_range(0, 15));
            step(u, ($urandom_range(0, 29) != 0), ($urandom_range(0, 39) == 0));
            if (u > 9) u = 0;
        end

        // Reset in the middle of activity, then restart
        count_run(9);
        step(0, 1, 0);
        do_reset("midrst");
        count_run(9);
        step(0, 1, 0);
        step(1, 1, 0);
        step(2, 1, 0);

        @(posedge clk);
        #2;
        mon_en = 0;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bcd_tally_display
`default_nettype wire
